// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD stopwatch/timer core.
// Holds the state encoding, nibble width and BCD saturation.
package timer_pkg;

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PAUSE = 3'd2,
    ST_SET   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Clamp a keypad nibble into the legal BCD range.
  function automatic logic [3:0] bcd_sat(
    input logic [3:0] n
  );
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One BCD digit of the up/down count chain (combinational step).
// Ports: digit_i current value, en/carry_in step request, down
// direction; digit_o stepped value, carry_out ripple to next digit.
module bcd_updown_digit (
  input  logic [3:0] digit_i,
  input  logic       en,
  input  logic       down,
  input  logic       carry_in,
  output logic [3:0] digit_o,
  output logic       carry_out
);

  logic step;
  logic wrap;

  assign step = en & carry_in;
  assign wrap = down ? (digit_i == 4'd0)
                     : (digit_i == 4'd9);

  always_comb begin
    digit_o = digit_i;
    if (step) begin
      if (down)
        digit_o = wrap ? 4'd9 : digit_i - 4'd1;
      else
        digit_o = wrap ? 4'd0 : digit_i + 4'd1;
    end
  end

  assign carry_out = step & wrap;

endmodule

// File: rtl/bcd_timer_core.sv
// Stopwatch/timer control: FSM, prescaler, BCD count, limit, lap.
// Ports: clk/reset, command pulses, cmd_set level + set_val limit,
// mode_down; outputs count/lap BCD, state, running, done, tick_o.
module bcd_timer_core
  import timer_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000000,
  parameter int DIV_W   = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic                  cmd_pause,
  input  logic                  cmd_clear,
  input  logic                  cmd_set,
  input  logic [4*DIGITS-1:0]   set_val,
  input  logic                  mode_down,
  input  logic                  cmd_lap,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [4*DIGITS-1:0]   lap_bcd,
  output logic [STATE_W-1:0]    state_o,
  output logic                  running,
  output logic                  done,
  output logic                  tick_o
);

  localparam int W = NIB_W * DIGITS;
  localparam logic [DIV_W-1:0] DIV_MAX =
    DIV_W'(CLK_DIV - 1);

  state_t           state_q;
  logic [DIV_W-1:0] presc_q;
  logic [W-1:0]     count_q;
  logic [W-1:0]     lap_q;
  logic [W-1:0]     limit_q;
  logic             mode_q;
  logic             tick_q;

  logic [W-1:0]     cnt_step;
  logic [W-1:0]     set_sat;
  logic [DIGITS:0]  cy;
  logic             carry_unused;
  logic             tick_now;
  logic             done_hit;
  logic             lap_ok;
  logic [W-1:0]     start_cnt;
  state_t           start_st;

  assign tick_now = (state_q == ST_RUN) &&
                    (presc_q == DIV_MAX);

  assign cy[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_updown_digit u_dig (
      .digit_i   (count_q[4*g +: 4]),
      .en        (tick_now),
      .down      (mode_q),
      .carry_in  (cy[g]),
      .digit_o   (cnt_step[4*g +: 4]),
      .carry_out (cy[g+1])
    );
  end

  // Full-width wrap is implicit in the digit chain.
  assign carry_unused = cy[DIGITS];

  always_comb begin
    set_sat = '0;
    for (int i = 0; i < DIGITS; i++)
      set_sat[4*i +: 4] = bcd_sat(set_val[4*i +: 4]);
  end

  // limit==0 in up mode means free-run, never done.
  assign done_hit = mode_q ? (cnt_step == '0)
                  : ((limit_q != '0) &&
                     (cnt_step == limit_q));

  // Common entry into RUN from IDLE, SET and DONE.
  assign start_cnt = mode_down ? limit_q : '0;
  assign start_st  = (mode_down && limit_q == '0)
                   ? ST_DONE : ST_RUN;

  assign lap_ok = (state_q == ST_RUN) ||
                  (state_q == ST_PAUSE) ||
                  (state_q == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      count_q <= '0;
      lap_q   <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (cmd_lap && lap_ok)
        lap_q <= count_q;
      if (cmd_clear) begin
        state_q <= ST_IDLE;
        count_q <= '0;
        presc_q <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (cmd_set) begin
              state_q <= ST_SET;
              limit_q <= set_sat;
              count_q <= set_sat;
            end else if (cmd_start) begin
              state_q <= start_st;
              count_q <= start_cnt;
              presc_q <= '0;
              mode_q  <= mode_down;
            end
          end
          ST_RUN: begin
            presc_q <= tick_now ? '0
                     : presc_q + DIV_W'(1);
            if (tick_now) begin
              count_q <= cnt_step;
              tick_q  <= 1'b1;
            end
            if (tick_now && done_hit)
              state_q <= ST_DONE;
            else if (cmd_pause)
              state_q <= ST_PAUSE;
          end
          ST_PAUSE: begin
            if (cmd_set) begin
              state_q <= ST_SET;
              limit_q <= set_sat;
              count_q <= set_sat;
            end else if (cmd_pause || cmd_start) begin
              state_q <= ST_RUN;
            end
          end
          ST_SET: begin
            if (cmd_set) begin
              limit_q <= set_sat;
              count_q <= set_sat;
            end else begin
              state_q <= start_st;
              count_q <= start_cnt;
              presc_q <= '0;
              mode_q  <= mode_down;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign count_bcd = count_q;
  assign lap_bcd   = lap_q;
  assign state_o   = state_q;
  assign running   = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign tick_o    = tick_q;

endmodule
